// File: rtl/nn_mac_sequencer.sv
// nn_mac_sequencer: time-multiplexed 4-4-2 fully connected network.
// A single DATA_W multiply-accumulate unit walks layer 1 (hidden units) and
// then layer 2 (outputs) one product per cycle, using a local weight file.
// All arithmetic wraps modulo 2^DATA_W; there is no activation or saturation.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid is high only in
// DONE, where out_vec is held stable until out_ready is seen.
module nn_mac_sequencer #(
    parameter int DATA_W = 16,
    parameter int N_IN   = 4,
    parameter int N_HID  = 4,
    parameter int N_OUT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4:0]              wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_drop,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*DATA_W-1:0]  in_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT*DATA_W-1:0] out_vec,
    output logic                    busy
);

    localparam int N_W    = N_IN * N_HID + N_HID * N_OUT;
    localparam int ADDR_W = 5;
    localparam int MAX_AB = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int MAX_N  = (MAX_AB > N_OUT) ? MAX_AB : N_OUT;
    localparam int CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0]  IN_LAST    = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0]  HID_LAST   = CNT_W'(N_HID - 1);
    localparam logic [CNT_W-1:0]  OUT_LAST   = CNT_W'(N_OUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(N_W);
    localparam int                L2_BASE    = N_IN * N_HID;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L1   = 2'd1,
        S_L2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Weight file, latched input vector, hidden results and output results
    // are kept as flat packed vectors indexed by element.
    logic [N_W*DATA_W-1:0]   w_mem;
    logic [N_IN*DATA_W-1:0]  x_reg;
    logic [N_HID*DATA_W-1:0] y_reg;
    logic [N_OUT*DATA_W-1:0] out_reg;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] sum;

    // inner walks the summed index, outer walks the unit being produced
    logic [CNT_W-1:0] inner;
    logic [CNT_W-1:0] outer;
    logic             inner_last;
    logic             outer_last;
    logic             wr_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, handshake outputs and loop-end flags
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        inner_last = 1'b0;
        outer_last = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_L1;
                end
            end
            S_L1: begin
                busy       = 1'b1;
                inner_last = (inner == IN_LAST);
                outer_last = (outer == HID_LAST);
                if (inner_last && outer_last) begin
                    state_next = S_L2;
                end
            end
            S_L2: begin
                busy       = 1'b1;
                inner_last = (inner == HID_LAST);
                outer_last = (outer == OUT_LAST);
                if (inner_last && outer_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // MAC operand select: layer 1 uses x[i]*w[i][h], layer 2 uses y[h]*w[h][o]
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (state)
            S_L1: begin
                mac_a = x_reg[int'(inner)*DATA_W +: DATA_W];
                mac_b = w_mem[(int'(inner)*N_HID + int'(outer))*DATA_W +: DATA_W];
            end
            S_L2: begin
                mac_a = y_reg[int'(inner)*DATA_W +: DATA_W];
                mac_b = w_mem[(L2_BASE + int'(inner)*N_OUT + int'(outer))*DATA_W +: DATA_W];
            end
            default: begin
                mac_a = '0;
                mac_b = '0;
            end
        endcase
    end

    // Products and sums are truncated to DATA_W by the operand widths.
    assign prod = mac_a * mac_b;
    assign sum  = acc + prod;

    // Writes land only while no vector is in flight and the address exists.
    assign wr_ok = (wr_addr < ADDR_LIMIT) && ((state == S_IDLE) || (state == S_DONE));

    // Weight file update and one-cycle rejection pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_mem   <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && !wr_ok;
            if (wr_en && wr_ok) begin
                w_mem[int'(wr_addr)*DATA_W +: DATA_W] <= wr_data;
            end
        end
    end

    // Datapath: input latch, accumulator, loop counters and result stores
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            out_reg <= '0;
            acc     <= '0;
            inner   <= '0;
            outer   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_reg <= in_vec;
                        acc   <= '0;
                        inner <= '0;
                        outer <= '0;
                    end
                end
                S_L1, S_L2: begin
                    if (inner_last) begin
                        if (state == S_L1) begin
                            y_reg[int'(outer)*DATA_W +: DATA_W] <= sum;
                        end else begin
                            out_reg[int'(outer)*DATA_W +: DATA_W] <= sum;
                        end
                        acc   <= '0;
                        inner <= '0;
                        outer <= outer_last ? '0 : (outer + CNT_W'(1));
                    end else begin
                        acc   <= sum;
                        inner <= inner + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_vec = out_reg;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// tb_nn_mac_sequencer: directed and randomized checks of nn_mac_sequencer.
// Expected results come from a plain-arithmetic model of the 4-4-2 network
// (or from hand-computed constants for the directed cases) and are queued at
// accept time; an independent monitor pops them when the DUT hands a result
// downstream.
module tb_nn_mac_sequencer;

    localparam int DATA_W = 16;
    localparam int N_IN   = 4;
    localparam int N_HID  = 4;
    localparam int N_OUT  = 2;
    localparam int N_W    = 24;
    localparam int LAT    = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    wr_en = 1'b0;
    logic [4:0]              wr_addr = '0;
    logic [DATA_W-1:0]       wr_data = '0;
    logic                    wr_drop;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [N_IN*DATA_W-1:0]  in_vec = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [N_OUT*DATA_W-1:0] out_vec;
    logic                    busy;

    nn_mac_sequencer #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_drop  (wr_drop),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_vec   (in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .busy     (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    int acc_q[$];
    logic [15:0] w_model[N_W];
    int last_acc = -1000;
    int b2b_prev = -1;
    logic b2b_chk = 1'b0;
    logic dir_en = 1'b0;
    logic [31:0] dir_exp = '0;
    int busy_run = 0;
    logic ov_prev = 1'b0;
    int mon_t;
    int acc_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name, input int limit);
        total++;
        bad++;
        $display("FAIL %s: no event within %0d cycles, expected one (cycle %0d)", name, limit, cyc);
    endtask

    // Network reference: y[h] = sum_i x[i]*w1[i][h], out[o] = sum_h y[h]*w2[h][o], mod 2^16
    function automatic logic [31:0] model(input logic [63:0] x);
        logic [63:0] s;
        logic [15:0] y[N_HID];
        logic [15:0] o_v[N_OUT];
        for (int h = 0; h < N_HID; h++) begin
            s = '0;
            for (int i = 0; i < N_IN; i++)
                s = s + 64'(x[i*16 +: 16]) * 64'(w_model[i*N_HID + h]);
            y[h] = s[15:0];
        end
        for (int o = 0; o < N_OUT; o++) begin
            s = '0;
            for (int h = 0; h < N_HID; h++)
                s = s + 64'(y[h]) * 64'(w_model[16 + h*N_OUT + o]);
            o_v[o] = s[15:0];
        end
        return {o_v[1], o_v[0]};
    endfunction

    // Accept watcher: the handshake completes on the coming edge, so queue the expectation now
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            acc_t = cyc + 1;
            if (b2b_chk && b2b_prev >= 0)
                chk("accept_spacing", 64'(acc_t - b2b_prev), 64'd26);
            b2b_prev = acc_t;
            last_acc = acc_t;
            acc_q.push_back(acc_t);
            exp_q.push_back(dir_en ? dir_exp : model(in_vec));
        end
    end

    // Monitor: latency/busy at out_valid rise, result compare on each output transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_run++;
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_valid_rise: got unexpected rise, expected none (cycle %0d)", cyc);
                end else begin
                    mon_t = acc_q.pop_front();
                    chk("latency", 64'(cyc - mon_t), 64'(LAT));
                    chk("busy_cycles", 64'(busy_run), 64'(LAT));
                end
                busy_run = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_xfer: got unexpected result %0h, expected none (cycle %0d)", out_vec, cyc);
                end else begin
                    chk("out_vec", 64'(out_vec), 64'(exp_q.pop_front()));
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        exp_q.delete();
        acc_q.delete();
        for (int k = 0; k < N_W; k++) w_model[k] = '0;
        last_acc = -1000;
        b2b_prev = -1;
        busy_run = 0;
        ov_prev = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wr_drop", 64'(wr_drop), 64'd0);
        chk("rst_out_vec", 64'(out_vec), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_w(input logic [4:0] a, input logic [15:0] d);
        int e;
        logic exp_drop;
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        e = cyc + 1;
        exp_drop = (int'(a) >= N_W) || (e >= last_acc + 1 && e <= last_acc + LAT);
        if (!exp_drop) w_model[a] = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("wr_drop", 64'(wr_drop), 64'(exp_drop));
    endtask

    task automatic write_all(input logic [15:0] d);
        for (int k = 0; k < N_W; k++) write_w(5'(k), d);
    endtask

    // Returns with the accept edge just passed
    task automatic send_vec(input logic [63:0] v);
        int n;
        @(posedge clk);
        #1;
        in_vec = v;
        in_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 200) timeout_fail("send_vec", 200);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input logic bp);
        int n;
        for (n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (n == 400) timeout_fail("wait_idle", 400);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    // Hard stop if the sequence itself hangs
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected end", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        do_reset();

        // All weights 1, x={1,2,3,4}: y=10, out=40
        write_all(16'd1);
        dir_en = 1'b1;
        dir_exp = {16'd40, 16'd40};
        send_vec({16'd4, 16'd3, 16'd2, 16'd1});
        wait_idle(1'b0);

        // Wrap: 0x100*0x100 vanishes, 4*0xFF00 wraps to 0xFC00
        for (int h = 0; h < N_HID; h++) write_w(5'(h), 16'h0100);
        dir_exp = 32'h0000_0000;
        send_vec({16'h0, 16'h0, 16'h0, 16'h0100});
        wait_idle(1'b0);
        for (int h = 0; h < N_HID; h++) write_w(5'(h), 16'h00FF);
        dir_exp = {16'hFC00, 16'hFC00};
        send_vec({16'h0, 16'h0, 16'h0, 16'h0100});
        wait_idle(1'b0);

        // Write at accept+3 is dropped and leaves the result unchanged
        for (int h = 0; h < N_HID; h++) write_w(5'(h), 16'd1);
        dir_exp = {16'd40, 16'd40};
        send_vec({16'd4, 16'd3, 16'd2, 16'd1});
        @(posedge clk);
        write_w(5'd0, 16'h0007);
        wait_idle(1'b0);
        write_w(5'd25, 16'h1234);

        // Backpressure in DONE
        out_ready = 1'b0;
        send_vec({16'd4, 16'd3, 16'd2, 16'd1});
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (n == 100) timeout_fail("bp_out_valid", 100);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_vec = {16'd9, 16'd9, 16'd9, 16'd9};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_vec", 64'(out_vec), 64'(dir_exp));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset at accept+10 aborts; weights are zero afterwards
        send_vec({16'd4, 16'd3, 16'd2, 16'd1});
        repeat (8) @(posedge clk);
        do_reset();
        dir_exp = 32'h0;
        send_vec({16'h1111, 16'h2222, 16'h3333, 16'h4444});
        wait_idle(1'b0);

        // Randomized weights, vectors, backpressure and concurrent writes
        dir_en = 1'b0;
        for (int k = 0; k < N_W; k++) write_w(5'(k), 16'($urandom));
        fork
            begin
                for (int v = 0; v < 8; v++) begin
                    send_vec({$urandom, $urandom});
                    wait_idle(1'b1);
                end
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    repeat ($urandom_range(0, 25)) @(posedge clk);
                    write_w(5'($urandom_range(0, 27)), 16'($urandom));
                end
            end
        join

        // Back-to-back with in_valid held high: accepts 26 cycles apart
        b2b_chk = 1'b1;
        b2b_prev = -1;
        @(posedge clk);
        #1;
        in_vec = {$urandom, $urandom};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (n = 0; n < 100; n++) begin
                @(negedge clk);
                if (in_ready) break;
            end
            if (n == 100) timeout_fail("b2b_accept", 100);
            @(posedge clk);
            #1;
            in_vec = {$urandom, $urandom};
        end
        in_valid = 1'b0;
        wait_idle(1'b0);
        b2b_chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
